// File: rtl/stpm_multi_ch_pkg.sv
// Shared types, step-table constants and phase lookup for the stepper sequencer.
// Build option: STPM_HALF_STEP_EN selects the 8-entry half-step table (else 4-entry full-step wave).
package stpm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int IDX_W = 3;

`ifdef STPM_HALF_STEP_EN
  localparam int SPC = 8;
  // Entry k sits at bits [4k+:4]: 0001,0011,0010,0110,0100,1100,1000,1001
  localparam logic [4*SPC-1:0] PHASE_TBL = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                            4'b0110, 4'b0010, 4'b0011, 4'b0001};
`else
  localparam int SPC = 4;
  localparam logic [4*SPC-1:0] PHASE_TBL = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
`endif

  function automatic logic [3:0] phase_of(input logic [IDX_W-1:0] idx);
    int unsigned sel;
    sel = 32'(idx) % SPC;
    return PHASE_TBL[sel*4 +: 4];
  endfunction

endpackage

// File: rtl/stpm_multi_ch_if.sv
// Per-channel handshake, run parameters and coil outputs of the multi-channel sequencer.
// Identical in both step-table builds (STPM_HALF_STEP_EN defined or not).
interface stpm_multi_ch_if #(
  parameter int N_MOTORS = 4,
  parameter int CYC_W    = 10
);
  logic [N_MOTORS-1:0]       i_En;
  logic [N_MOTORS-1:0]       i_Start;
  logic [N_MOTORS-1:0]       i_Dir;
  logic [N_MOTORS*CYC_W-1:0] i_Cycles;
  logic [N_MOTORS-1:0]       o_Busy;
  logic [N_MOTORS-1:0]       o_Done;
  logic [N_MOTORS*4-1:0]     o_Phase;

  modport master (output i_En, i_Start, i_Dir, i_Cycles,
                  input  o_Busy, o_Done, o_Phase);
  modport slave  (input  i_En, i_Start, i_Dir, i_Cycles,
                  output o_Busy, o_Done, o_Phase);
endinterface

// File: rtl/stpm_multi_ch_channel.sv
// One motor channel: start/abort FSM, step counter and phase index.
// Table length follows STPM_HALF_STEP_EN through stpm_pkg::SPC.
//   state   | meaning
//   ST_IDLE | coils off, waiting for an enabled start
//   ST_RUN  | driving pattern(idx), advancing on each shared tick
module stpm_channel
  import stpm_pkg::*;
#(
  parameter int CYC_W = 10
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             tick,
  input  logic             en,
  input  logic             start,
  input  logic             dir,
  input  logic [CYC_W-1:0] cycles,
  output logic             busy,
  output logic             done,
  output logic [3:0]       phase
);
  localparam int SC_W = CYC_W + 3;

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;
  logic [SC_W-1:0]    last_q, last_d;
  logic [SC_W-1:0]    step_q, step_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   idx_inc, idx_dec;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= '0;
      step_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      last_q  <= last_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    idx_inc = (idx_q == IDX_W'(SPC-1)) ? '0 : idx_q + 1'b1;
    idx_dec = (idx_q == '0) ? IDX_W'(SPC-1) : idx_q - 1'b1;
    state_d = state_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    last_d  = last_q;
    step_d  = step_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start && en) begin
          dir_d  = dir;
          step_d = '0;
          idx_d  = '0;
          if (cycles == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            last_d  = SC_W'(cycles) * SC_W'(SPC) - SC_W'(1);
          end
        end
      end
      ST_RUN: begin
        // Abort wins over a completing tick so an aborted run never reports done.
        if (!en) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (step_q == last_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 1'b1;
            idx_d  = dir_q ? idx_dec : idx_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == ST_RUN);
    done  = done_q;
    phase = busy ? phase_of(idx_q) : 4'b0000;
  end

endmodule

// File: rtl/stpm_multi_ch.sv
// N-channel stepper phase sequencer: shared step-rate prescaler plus one stpm_channel per motor.
// Build option: STPM_HALF_STEP_EN (half-step table, 8 steps per electrical cycle).
module stpm_multi_ch
  import stpm_pkg::*;
#(
  parameter int N_MOTORS = 4,
  parameter int CYC_W    = 10,
  parameter int STEP_DIV = 50000
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  stpm_multi_ch_if.slave   bus
);
  localparam int PS_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  logic [PS_W-1:0]       ps_q, ps_d;
  logic                  tick;
  logic [N_MOTORS-1:0]   busy_w;
  logic [N_MOTORS-1:0]   done_w;
  logic [N_MOTORS*4-1:0] phase_w;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) ps_q <= '0;
    else          ps_q <= ps_d;
  end

  always_comb begin
    tick = (ps_q == PS_W'(STEP_DIV-1));
    ps_d = tick ? '0 : ps_q + 1'b1;
  end

  for (genvar k = 0; k < N_MOTORS; k++) begin : g_ch
    stpm_channel #(.CYC_W(CYC_W)) u_ch (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .tick    (tick),
      .en      (bus.i_En[k]),
      .start   (bus.i_Start[k]),
      .dir     (bus.i_Dir[k]),
      .cycles  (bus.i_Cycles[k*CYC_W +: CYC_W]),
      .busy    (busy_w[k]),
      .done    (done_w[k]),
      .phase   (phase_w[k*4 +: 4])
    );
  end

  assign bus.o_Busy  = busy_w;
  assign bus.o_Done  = done_w;
  assign bus.o_Phase = phase_w;

endmodule

// File: tb/tb_stpm_multi_ch.sv
// Self-checking bench for stpm_multi_ch with STEP_DIV=4; expected coil sequences come from the step table.
// Follows STPM_HALF_STEP_EN for its own reference table.
module tb_stpm_multi_ch;
  localparam int NM = 4;
  localparam int CW = 10;
  localparam int SD = 4;
`ifdef STPM_HALF_STEP_EN
  localparam int SPC = 8;
  localparam logic [3:0] TBL [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h4, 4'hC, 4'h8, 4'h9};
`else
  localparam int SPC = 4;
  localparam logic [3:0] TBL [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stpm_multi_ch_if #(.N_MOTORS(NM), .CYC_W(CW)) bus ();

  stpm_multi_ch #(.N_MOTORS(NM), .CYC_W(CW), .STEP_DIV(SD)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  logic [NM*4-1:0] cap_ph [$];
  logic [NM-1:0]   cap_bz [$];
  logic [NM-1:0]   cap_dn [$];
  int obs_pat [$];
  int obs_len [$];
  int first_nz, last_nz, done_cnt, first_done, busy_bad;

  task automatic set_ch(input int ch, input bit dir, input int cyc);
    bus.i_Dir[ch] = dir;
    bus.i_Cycles[ch*CW +: CW] = CW'(cyc);
  endtask

  // Caller sets i_Start just after a falling edge; it is cleared after the first sample.
  task automatic capture(input int ncyc);
    cap_ph.delete(); cap_bz.delete(); cap_dn.delete();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      cap_ph.push_back(bus.o_Phase);
      cap_bz.push_back(bus.o_Busy);
      cap_dn.push_back(bus.o_Done);
      if (i == 0) bus.i_Start = '0;
    end
  endtask

  function automatic void extract(input int ch);
    logic [3:0] p, prev;
    obs_pat.delete(); obs_len.delete();
    first_nz = -1; last_nz = -1; done_cnt = 0; first_done = -1; busy_bad = 0;
    prev = 4'h0;
    for (int i = 0; i < cap_ph.size(); i++) begin
      p = cap_ph[i][ch*4 +: 4];
      if (p != 4'h0) begin
        if (p != prev) begin
          obs_pat.push_back(int'(p));
          obs_len.push_back(1);
        end else begin
          obs_len[obs_len.size()-1] = obs_len[obs_len.size()-1] + 1;
        end
        if (first_nz < 0) first_nz = i;
        last_nz = i;
      end
      prev = p;
      if (cap_dn[i][ch]) begin
        if (first_done < 0) first_done = i;
        done_cnt++;
      end
      if (cap_bz[i][ch] != (p != 4'h0)) busy_bad++;
    end
  endfunction

  task automatic verify_run(input int ch, input bit dir, input int cyc, input string nm);
    int total, bad, badlen, e;
    extract(ch);
    if (cyc == 0) begin
      n_chk++;
      if (obs_pat.size() != 0) begin
        n_err++; $display("FAIL %s_no_coils got=%0d patterns exp=0", nm, obs_pat.size());
      end
      n_chk++;
      if (done_cnt != 1 || first_done != 0) begin
        n_err++; $display("FAIL %s_zero_done got cnt=%0d at=%0d exp cnt=1 at=0", nm, done_cnt, first_done);
      end
    end else begin
      total = cyc * SPC; bad = 0; badlen = 0;
      n_chk++;
      if (obs_pat.size() != total) begin
        n_err++; $display("FAIL %s_pattern_count got=%0d exp=%0d", nm, obs_pat.size(), total);
      end
      for (int k = 0; k < total; k++) begin
        e = dir ? (SPC - (k % SPC)) % SPC : k % SPC;
        if (k >= obs_pat.size() || obs_pat[k] != int'(TBL[e])) bad++;
      end
      n_chk++;
      if (bad != 0) begin
        n_err++; $display("FAIL %s_pattern_seq got=%0d wrong entries exp=0", nm, bad);
      end
      n_chk++;
      if (first_nz != 0) begin
        n_err++; $display("FAIL %s_first_pattern_clk got=%0d exp=0", nm, first_nz);
      end
      if (obs_len.size() > 0 && (obs_len[0] < 1 || obs_len[0] > SD)) badlen++;
      for (int k = 1; k < obs_len.size(); k++) if (obs_len[k] != SD) badlen++;
      n_chk++;
      if (badlen != 0) begin
        n_err++; $display("FAIL %s_step_spacing got=%0d bad lengths exp=0", nm, badlen);
      end
      n_chk++;
      if (done_cnt != 1 || first_done != last_nz + 1) begin
        n_err++; $display("FAIL %s_done_pulse got cnt=%0d at=%0d exp cnt=1 at=%0d", nm, done_cnt, first_done, last_nz + 1);
      end
    end
    n_chk++;
    if (busy_bad != 0) begin
      n_err++; $display("FAIL %s_busy_vs_coils got=%0d bad clks exp=0", nm, busy_bad);
    end
  endtask

  task automatic test_reset();
    int act;
    rst_n = 1'b0;
    bus.i_En = '1; bus.i_Start = '0; bus.i_Dir = '0; bus.i_Cycles = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.o_Phase !== '0) begin n_err++; $display("FAIL reset_phase got=%h exp=0", bus.o_Phase); end
    n_chk++;
    if (bus.o_Busy !== '0) begin n_err++; $display("FAIL reset_busy got=%h exp=0", bus.o_Busy); end
    n_chk++;
    if (bus.o_Done !== '0) begin n_err++; $display("FAIL reset_done got=%h exp=0", bus.o_Done); end
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_Phase !== '0 || bus.o_Busy !== '0 || bus.o_Done !== '0) act++;
    end
    n_chk++;
    if (act != 0) begin n_err++; $display("FAIL idle_quiet got=%0d active clks exp=0", act); end
  endtask

  task automatic test_fwd_two();
    set_ch(0, 1'b0, 2);
    bus.i_Start = 4'b0001;
    capture(2*SPC*SD + 12);
    verify_run(0, 1'b0, 2, "ch0_fwd2");
  endtask

  task automatic test_bwd_and_zero();
    set_ch(1, 1'b1, 1);
    set_ch(2, 1'b0, 0);
    bus.i_Start = 4'b0110;
    capture(SPC*SD + 12);
    verify_run(1, 1'b1, 1, "ch1_bwd1");
    verify_run(2, 1'b0, 0, "ch2_zero");
  endtask

  task automatic test_one_cycle();
    set_ch(0, 1'b0, 1);
    bus.i_Start = 4'b0001;
    capture(SPC*SD + 12);
    verify_run(0, 1'b0, 1, "ch0_table");
  endtask

  task automatic test_abort();
    logic [3:0] p, prev;
    int pats, seq_bad, post;
    bit dropped, saw_done;
    pats = 0; seq_bad = 0; post = 0; dropped = 0; saw_done = 0; prev = 4'h0;
    bus.i_En = '1;
    set_ch(3, 1'b0, 5);
    bus.i_Start = 4'b1000;
    for (int i = 0; i < 200 && post < 30; i++) begin
      @(negedge clk);
      p = bus.o_Phase[12 +: 4];
      if (bus.o_Done[3]) saw_done = 1;
      if (dropped) begin
        post++;
        if (post == 1) begin
          n_chk++;
          if (p !== 4'h0) begin n_err++; $display("FAIL abort_coils_off got=%h exp=0", p); end
          n_chk++;
          if (bus.o_Busy[3] !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", bus.o_Busy[3]); end
        end
      end else begin
        if (p != 4'h0 && p != prev) begin
          if (p != TBL[pats % SPC]) seq_bad++;
          pats++;
        end
        prev = p;
        // Restart attempt mid-run with different direction and length.
        if (i == 5) begin set_ch(3, 1'b1, 1); bus.i_Start[3] = 1'b1; end
        else bus.i_Start[3] = 1'b0;
        if (pats == 7) begin bus.i_En[3] = 1'b0; dropped = 1; end
      end
    end
    bus.i_Start = '0;
    n_chk++;
    if (!dropped) begin n_err++; $display("FAIL abort_reached_tick6 got=%0d patterns exp=7", pats); end
    n_chk++;
    if (seq_bad != 0) begin n_err++; $display("FAIL abort_restart_ignored got=%0d wrong exp=0", seq_bad); end
    n_chk++;
    if (saw_done) begin n_err++; $display("FAIL abort_no_done got=1 exp=0"); end
    bus.i_En = '1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [NM-1:0] mask, en;
    bit dirs [NM];
    int cycs [NM];
    for (int it = 0; it < 10; it++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      mask = NM'($urandom);
      en   = NM'($urandom) | NM'($urandom);
      for (int c = 0; c < NM; c++) begin
        dirs[c] = 1'($urandom);
        cycs[c] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3));
        set_ch(c, dirs[c], cycs[c]);
      end
      bus.i_En = en;
      bus.i_Start = mask;
      capture(3*SPC*SD + 12);
      for (int c = 0; c < NM; c++) begin
        if (mask[c] && en[c]) begin
          verify_run(c, dirs[c], cycs[c], $sformatf("rnd%0d_ch%0d", it, c));
        end else begin
          extract(c);
          n_chk++;
          if (obs_pat.size() != 0 || done_cnt != 0) begin
            n_err++;
            $display("FAIL rnd%0d_ch%0d_not_started got patterns=%0d done=%0d exp 0/0", it, c, obs_pat.size(), done_cnt);
          end
        end
      end
      bus.i_En = '1;
    end
  endtask

  task automatic test_max_cycles();
    bit dirs [NM];
    for (int c = 0; c < NM; c++) begin
      dirs[c] = 1'($urandom);
      set_ch(c, dirs[c], 1023);
    end
    bus.i_Start = '1;
    capture(1023*SPC*SD + 12);
    for (int c = 0; c < NM; c++) verify_run(c, dirs[c], 1023, $sformatf("max_ch%0d", c));
  endtask

  task automatic test_reset_midrun();
    for (int c = 0; c < NM; c++) set_ch(c, 1'($urandom), 7);
    bus.i_Start = '1;
    @(negedge clk);
    bus.i_Start = '0;
    repeat (30) @(negedge clk);
    n_chk++;
    if (bus.o_Busy !== '1) begin n_err++; $display("FAIL midrun_running got=%h exp=f", bus.o_Busy); end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.o_Phase !== '0) begin n_err++; $display("FAIL midrun_reset_phase got=%h exp=0", bus.o_Phase); end
    n_chk++;
    if (bus.o_Busy !== '0 || bus.o_Done !== '0) begin
      n_err++; $display("FAIL midrun_reset_flags got busy=%h done=%h exp 0/0", bus.o_Busy, bus.o_Done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_chk++;
    if (bus.o_Phase !== '0 || bus.o_Busy !== '0) begin
      n_err++; $display("FAIL midrun_stays_idle got phase=%h busy=%h exp 0/0", bus.o_Phase, bus.o_Busy);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_two();
    test_bwd_and_zero();
    test_one_cycle();
    test_abort();
    test_random();
    test_max_cycles();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
